// File: rtl/frame_commit_bridge.sv
// -----------------------------------------------------------------------------
// frame_commit_bridge
//
// Responder side of a four-phase req/ack snapshot handshake between the
// game-logic domain and the display path. A pending request is served only
// early in vertical blanking. The payload is copied into a shadow register,
// commit pulses, and ack is raised. ack stays high until the request drops.
// The pixel path therefore never sees a partly updated frame.
//
// Ports:
//   clk              main clock
//   rst_n_debounced  asynchronous active-low reset
//   req_async        request from the game domain (four-phase, level)
//   data_in          payload, stable while req_async is high and ack is low
//   vs_async         VGA vertical sync; low means vertical blank
//   ack              acknowledge back to the game domain (level)
//   data_out         committed frame payload
//   commit           one-cycle pulse, coincident with data_out updating
//   frame_cnt        count of synchronized VS falling edges (wraps)
//   drop_cnt         frames that ended without a commit (saturates)
//
// Optional feature, macro FRAME_DROP_CNT_EN:
//   defined   -> drop_cnt counts frames that closed with no commit. The frame
//                that ends at the first VS fall after reset is not counted.
//   undefined -> drop_cnt is tied to zero.
//
// Output timing: a commit decision is taken in a cycle where the window is
// open. commit, data_out and ack become visible on the following cycle, so a
// pending request shows commit one cycle after vs_s falls.
// -----------------------------------------------------------------------------
module frame_commit_bridge #(
  parameter int DATA_W       = 32,
  parameter int SYNC_STAGES  = 2,    // must be >= 2
  parameter int GUARD_CYCLES = 1000,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n_debounced,
  input  logic                   req_async,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   vs_async,
  output logic                   ack,
  output logic [DATA_W-1:0]      data_out,
  output logic                   commit,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [FRAME_CNT_W-1:0] drop_cnt
);

  localparam int                BLANK_W   = $clog2(GUARD_CYCLES + 1);
  localparam logic [BLANK_W-1:0] GUARD_MAX = BLANK_W'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WIN,
    ACK_HOLD
  } state_e;

  // Synchronizer chains. Bit 0 samples the pin, and the top bit is the synced value.
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] vs_sync_q,  vs_sync_d;
  logic                   vs_prev_q,  vs_prev_d;

  logic [BLANK_W-1:0]     blank_cnt_q, blank_cnt_d;
  state_e                 state_q,     state_d;
  logic                   ack_q,       ack_d;
  logic [DATA_W-1:0]      data_q,      data_d;
  logic                   commit_q,    commit_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic req_s;
  logic vs_s;
  logic vs_fall;
  logic window_open;

  assign req_s       = req_sync_q[SYNC_STAGES-1];
  assign vs_s        = vs_sync_q[SYNC_STAGES-1];
  assign vs_fall     = vs_prev_q & ~vs_s;
  assign window_open = ~vs_s & (blank_cnt_q < GUARD_MAX);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_async};
    vs_sync_d   = {vs_sync_q[SYNC_STAGES-2:0], vs_async};
    vs_prev_d   = vs_s;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(vs_fall);
    state_d     = state_q;
    ack_d       = ack_q;
    data_d      = data_q;
    commit_d    = 1'b0;

    // The blank counter measures how far into blanking we are. It saturates so
    // that a very long blank cannot wrap back into an open window.
    if (vs_s) begin
      blank_cnt_d = '0;
    end else if (blank_cnt_q < GUARD_MAX) begin
      blank_cnt_d = blank_cnt_q + BLANK_W'(1);
    end else begin
      blank_cnt_d = blank_cnt_q;
    end

    unique case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = WAIT_WIN;
        end
      end
      WAIT_WIN: begin
        if (!req_s) begin
          // Requester withdrew before being served. Abort without committing.
          state_d = IDLE;
        end else if (window_open) begin
          // data_in is stable by protocol while req is high and ack is low,
          // so it is sampled directly without its own synchronizer.
          data_d   = data_in;
          commit_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = ACK_HOLD;
        end
      end
      ACK_HOLD: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_debounced) begin
    if (!rst_n_debounced) begin
      req_sync_q  <= '0;
      vs_sync_q   <= '1;   // idle VS is high, so no blank is seen out of reset
      vs_prev_q   <= 1'b1;
      blank_cnt_q <= '0;
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      // NOTE: the shadow register is reset so the display path starts from a known payload.
      data_q      <= '0;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      req_sync_q  <= req_sync_d;
      vs_sync_q   <= vs_sync_d;
      vs_prev_q   <= vs_prev_d;
      blank_cnt_q <= blank_cnt_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ack       = ack_q;
  assign data_out  = data_q;
  assign commit    = commit_q;
  assign frame_cnt = frame_cnt_q;

`ifdef FRAME_DROP_CNT_EN
  // committed_q records whether the current frame has seen a commit.
  // seen_fall_q masks the partial frame between reset and the first VS fall.
  // A visible commit pulse can never coincide with vs_fall, because a
  // decision needs vs_s low one cycle earlier. The two updates never collide.
  logic                   committed_q, committed_d;
  logic                   seen_fall_q, seen_fall_d;
  logic [FRAME_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

  always_comb begin
    committed_d = committed_q;
    seen_fall_d = seen_fall_q;
    drop_cnt_d  = drop_cnt_q;
    if (vs_fall) begin
      if (seen_fall_q && !committed_q && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + FRAME_CNT_W'(1);
      end
      seen_fall_d = 1'b1;
      committed_d = 1'b0;
    end
    if (commit_q) begin
      committed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_debounced) begin
    if (!rst_n_debounced) begin
      committed_q <= 1'b0;
      seen_fall_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      committed_q <= committed_d;
      seen_fall_q <= seen_fall_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_commit_bridge.sv
// -----------------------------------------------------------------------------
// tb_frame_commit_bridge
//
// Directed testbench for frame_commit_bridge. A behavioural model tracks the
// handshake in terms of the synchronized pins: how long blanking has lasted,
// whether the request is armed or served, and frame counts. A compare process
// checks every DUT output against the model on each falling clock edge while
// out of reset. The stimulus sequence also checks literal hand-computed values.
// frame_cnt is 8 bits here so that a full wrap fits in a short run.
// -----------------------------------------------------------------------------
module tb_frame_commit_bridge;

  localparam int S  = 2;
  localparam int G  = 1000;
  localparam int DW = 32;
  localparam int FW = 8;

`ifdef FRAME_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [DW-1:0] din;
  logic          vs;
  logic          ack;
  logic [DW-1:0] data_out;
  logic          commit;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  frame_commit_bridge #(
    .DATA_W      (DW),
    .SYNC_STAGES (S),
    .GUARD_CYCLES(G),
    .FRAME_CNT_W (FW)
  ) dut (
    .clk            (clk),
    .rst_n_debounced(rst_n),
    .req_async      (req),
    .data_in        (din),
    .vs_async       (vs),
    .ack            (ack),
    .data_out       (data_out),
    .commit         (commit),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The synchronized view of a pin is the value the pin had
  // S edges earlier. Blanking is tracked as an unbounded age, so the window is
  // open while age < G. The handshake is described as "armed" (request has been
  // seen) and "served" (request has been committed).
  // ---------------------------------------------------------------------------
  bit          m_req_pipe [S];
  bit          m_vs_pipe  [S];
  bit          m_vs_prev;
  int          m_blank_age;
  bit          m_armed;
  bit          m_served;
  int          m_frames_seen;
  bit          m_frame_committed;
  int          m_drops;

  bit          e_ack;
  bit          e_commit;
  logic [DW-1:0] e_data;
  int          e_frame;
  int          e_drop;

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_req_pipe[i] = 1'b0;
      m_vs_pipe[i]  = 1'b1;
    end
    m_vs_prev         = 1'b1;
    m_blank_age       = 0;
    m_armed           = 1'b0;
    m_served          = 1'b0;
    m_frames_seen     = 0;
    m_frame_committed = 1'b0;
    m_drops           = 0;
    e_ack             = 1'b0;
    e_commit          = 1'b0;
    e_data            = '0;
    e_frame           = 0;
    e_drop            = 0;
  endtask

  task automatic model_step();
    bit rs, vsn, win, fall;
    rs   = m_req_pipe[S-1];
    vsn  = m_vs_pipe[S-1];
    win  = !vsn && (m_blank_age < G);
    fall = m_vs_prev && !vsn;

    e_commit = 1'b0;
    if (!rs) begin
      // Request gone: any handshake is over and ack is released.
      m_armed  = 1'b0;
      m_served = 1'b0;
      e_ack    = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else if (!m_served && win) begin
      m_served = 1'b1;
      e_commit = 1'b1;
      e_data   = din;
      e_ack    = 1'b1;
    end

    if (fall) begin
      e_frame = (e_frame + 1) % (1 << FW);
      if (m_frames_seen > 0 && !m_frame_committed) m_drops++;
      m_frames_seen++;
      m_frame_committed = 1'b0;
    end
    if (e_commit) m_frame_committed = 1'b1;
    e_drop = DROP_EN ? ((m_drops > 255) ? 255 : m_drops) : 0;

    m_blank_age = vsn ? 0 : m_blank_age + 1;
    m_vs_prev   = vsn;
    for (int i = S - 1; i > 0; i--) begin
      m_req_pipe[i] = m_req_pipe[i-1];
      m_vs_pipe[i]  = m_vs_pipe[i-1];
    end
    m_req_pipe[0] = req;
    m_vs_pipe[0]  = vs;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ack",       64'(ack),       64'(e_ack));
        check("commit",    64'(commit),    64'(e_commit));
        check("data_out",  64'(data_out),  64'(e_data));
        check("frame_cnt", 64'(frame_cnt), 64'(e_frame));
        check("drop_cnt",  64'(drop_cnt),  64'(e_drop));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},       64'(ack),       64'(0));
    check({tag, "_commit"},    64'(commit),    64'(0));
    check({tag, "_data_out"},  64'(data_out),  64'(0));
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
    check({tag, "_drop_cnt"},  64'(drop_cnt),  64'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1;
    req   = 1'b0;
    vs    = 1'b1;
    din   = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    cyc(3);
    rst_n = 1'b1;
    cyc(10);

    // Request pending before blank: commit S+1 cycles after the VS pin falls.
    req = 1'b1; din = 32'hDEADBEEF;
    cyc(10);
    check("pend_no_commit_vs_high", 64'(commit), 64'(0));
    check("pend_no_ack_vs_high",    64'(ack),    64'(0));
    vs = 1'b0;
    cyc(2);
    check("pend_commit_not_early", 64'(commit), 64'(0));
    cyc(1);
    check("pend_commit",    64'(commit),    64'(1));
    check("pend_data",      64'(data_out),  64'(32'hDEADBEEF));
    check("pend_ack",       64'(ack),       64'(1));
    check("pend_frame_cnt", 64'(frame_cnt), 64'(1));
    cyc(1);
    check("pend_commit_one_cycle", 64'(commit), 64'(0));
    req = 1'b0;
    cyc(2);
    check("ack_still_high", 64'(ack), 64'(1));
    cyc(1);
    check("ack_released", 64'(ack), 64'(0));
    cyc(40); vs = 1'b1; cyc(20);

    // Request raised 1500 cycles into blank: deferred to the next blank.
    vs = 1'b0;
    cyc(1500);
    req = 1'b1; din = 32'h12345678;
    cyc(300);
    check("late_no_commit_data", 64'(data_out), 64'(32'hDEADBEEF));
    check("late_no_ack",         64'(ack),      64'(0));
    vs = 1'b1;
    cyc(20);
    check("late_data_held", 64'(data_out), 64'(32'hDEADBEEF));
    vs = 1'b0;
    cyc(2);
    check("late_commit_not_early", 64'(commit), 64'(0));
    cyc(1);
    check("late_commit", 64'(commit),   64'(1));
    check("late_data",   64'(data_out), 64'(32'h12345678));
    req = 1'b0;
    cyc(40); vs = 1'b1; cyc(20);

    // Request withdrawn before blank: no commit, ack stays low.
    req = 1'b1; din = 32'hCAFEF00D;
    cyc(10);
    req = 1'b0;
    cyc(10);
    check("abort_ack",  64'(ack),      64'(0));
    check("abort_data", 64'(data_out), 64'(32'h12345678));
    vs = 1'b0;
    cyc(50);
    check("abort_data_after_blank", 64'(data_out), 64'(32'h12345678));
    vs = 1'b1; cyc(20);

    // Request rising inside an open window, then a second handshake that
    // arrives after the window closed and must wait for the next frame.
    vs = 1'b0;
    cyc(10);
    req = 1'b1; din = 32'h11111111;
    cyc(3);
    check("inwin_commit_not_early", 64'(commit), 64'(0));
    cyc(1);
    check("inwin_commit", 64'(commit),   64'(1));
    check("inwin_data",   64'(data_out), 64'(32'h11111111));
    req = 1'b0;
    cyc(10);
    check("inwin_ack_released", 64'(ack), 64'(0));
    cyc(1100);
    req = 1'b1; din = 32'h22222222;
    cyc(100);
    check("second_deferred_data", 64'(data_out), 64'(32'h11111111));
    check("second_deferred_ack",  64'(ack),      64'(0));
    vs = 1'b1; cyc(20);
    vs = 1'b0;
    cyc(3);
    check("second_commit", 64'(commit),   64'(1));
    check("second_data",   64'(data_out), 64'(32'h22222222));
    check("second_ack",    64'(ack),      64'(1));
    req = 1'b0;
    cyc(10); vs = 1'b1; cyc(20);

    // Reset asserted mid-WAIT_WIN with req held high.
    req = 1'b1; din = 32'hA5A5A5A5;
    cyc(10);
    pulse_reset();
    cyc(10);
    check("post_rst_no_commit", 64'(commit), 64'(0));
    check("post_rst_no_ack",    64'(ack),    64'(0));
    vs = 1'b0;
    cyc(3);
    check("post_rst_commit",    64'(commit),    64'(1));
    check("post_rst_data",      64'(data_out),  64'(32'hA5A5A5A5));
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));
    req = 1'b0;
    cyc(10); vs = 1'b1; cyc(20);

    // Drop counting: three idle frames, then a frame with a commit.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      vs = 1'b0; cyc(30);
      vs = 1'b1; cyc(30);
    end
    req = 1'b1; din = 32'h0BADCAFE;
    cyc(10);
    vs = 1'b0;
    cyc(4);
    check("drop_after_4th_fall",  64'(drop_cnt),  DROP_EN ? 64'(3) : 64'(0));
    check("drop_frame_cnt_4",     64'(frame_cnt), 64'(4));
    check("drop_commit_data",     64'(data_out),  64'(32'h0BADCAFE));
    req = 1'b0;
    cyc(20); vs = 1'b1; cyc(20);
    vs = 1'b0;
    cyc(4);
    check("drop_after_commit_frame", 64'(drop_cnt),  DROP_EN ? 64'(3) : 64'(0));
    check("drop_frame_cnt_5",        64'(frame_cnt), 64'(5));
    vs = 1'b1; cyc(20);

    // frame_cnt wrap and drop_cnt saturation.
    pulse_reset();
    for (int i = 0; i < (1 << FW); i++) begin
      vs = 1'b0; cyc(2);
      vs = 1'b1; cyc(2);
    end
    check("wrap_frame_cnt", 64'(frame_cnt), 64'(0));
    check("wrap_drop_cnt",  64'(drop_cnt),  DROP_EN ? 64'(255) : 64'(0));
    for (int i = 0; i < 4; i++) begin
      vs = 1'b0; cyc(2);
      vs = 1'b1; cyc(2);
    end
    check("wrap_frame_cnt_4", 64'(frame_cnt), 64'(4));
    check("drop_saturated",   64'(drop_cnt),  DROP_EN ? 64'(255) : 64'(0));
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
